// File: rtl/mem_stage.sv
// Memory stage: drives the data-memory handshake for loads/stores, stalls upstream
// while an access is in flight and registers the result (or error) for writeback.
module mem_stage #(
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        halt,
    input  logic [15:0] alu_result,
    input  logic [15:0] write_data,
    output logic        stall_out,
    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    output logic        m_rd,
    output logic        m_wr,
    output logic        m_createdump,
    input  logic [15:0] m_data_out,
    input  logic        m_done,
    input  logic        m_stall,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic        wb_err,
    output logic        wb_halt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALTED} state_t;

    // Counter value during the last permitted ISSUE/WAIT cycle.
    localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic        wb_valid_q, wb_valid_d;
    logic [15:0] wb_data_q, wb_data_d;
    logic        wb_err_q, wb_err_d;
    logic        wb_halt_q, wb_halt_d;

    logic is_mem, bad_op, done, expired;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wr_d         = wr_q;
        wb_valid_d   = 1'b0;
        wb_data_d    = wb_data_q;
        wb_err_d     = wb_err_q;
        wb_halt_d    = wb_halt_q;
        stall_out    = 1'b0;
        m_rd         = 1'b0;
        m_wr         = 1'b0;
        m_addr       = 16'h0000;
        m_data_in    = 16'h0000;
        m_createdump = 1'b0;
        done         = 1'b0;
        expired      = 1'b0;
        is_mem       = mem_read | mem_write;
        bad_op       = (mem_read & mem_write) | (is_mem & alu_result[0]);

        case (state_q)
            IDLE: begin
                cnt_d = 6'd0;
                if (in_valid) begin
                    if (halt) begin
                        m_createdump = 1'b1;
                        wb_valid_d   = 1'b1;
                        wb_halt_d    = 1'b1;
                        wb_err_d     = 1'b0;
                        wb_data_d    = alu_result;
                        state_d      = HALTED;
                    end else if (bad_op) begin
                        wb_valid_d = 1'b1;
                        wb_err_d   = 1'b1;
                        wb_halt_d  = 1'b0;
                        wb_data_d  = 16'h0000;
                    end else if (is_mem) begin
                        stall_out = 1'b1;
                        addr_d    = alu_result;
                        data_d    = write_data;
                        wr_d      = mem_write;
                        state_d   = ISSUE;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_err_d   = 1'b0;
                        wb_halt_d  = 1'b0;
                        wb_data_d  = alu_result;
                    end
                end
            end
            ISSUE, WAIT: begin
                m_addr    = addr_q;
                m_data_in = data_q;
                if (state_q == ISSUE) begin
                    m_wr = wr_q;
                    m_rd = ~wr_q;
                    done = ~m_stall & m_done;
                    if (!m_stall) state_d = WAIT;
                end else begin
                    done = m_done;
                end
                cnt_d     = cnt_q + 6'd1;
                expired   = (cnt_q == CNT_LAST);
                stall_out = ~(done | expired);
                // Completion beats a timeout landing in the same cycle.
                if (done) begin
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b0;
                    wb_halt_d  = 1'b0;
                    wb_data_d  = wr_q ? addr_q : m_data_out;
                    state_d    = IDLE;
                end else if (expired) begin
                    wb_valid_d = 1'b1;
                    wb_err_d   = 1'b1;
                    wb_halt_d  = 1'b0;
                    wb_data_d  = 16'h0000;
                    state_d    = IDLE;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            stall_out    = 1'b0;
            m_createdump = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            addr_q     <= 16'h0000;
            data_q     <= 16'h0000;
            wr_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= 16'h0000;
            wb_err_q   <= 1'b0;
            wb_halt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_err_q   <= wb_err_d;
            wb_halt_q  <= wb_halt_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_err   = wb_err_q;
    assign wb_halt  = wb_halt_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instruction
// streams checked against a transaction-level latency/result model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_read, mem_write, halt;
    logic [15:0] alu_result, write_data;
    logic        stall_out;
    logic [15:0] m_addr, m_data_in;
    logic        m_rd, m_wr, m_createdump;
    logic [15:0] m_data_out;
    logic        m_done, m_stall;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic        wb_err, wb_halt;

    int tests_run = 0;
    int tests_failed = 0;

    localparam int TMO = 63;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .halt(halt), .alu_result(alu_result),
        .write_data(write_data), .stall_out(stall_out), .m_addr(m_addr),
        .m_data_in(m_data_in), .m_rd(m_rd), .m_wr(m_wr),
        .m_createdump(m_createdump), .m_data_out(m_data_out), .m_done(m_done),
        .m_stall(m_stall), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_err(wb_err), .wb_halt(wb_halt)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got running, need finished");
        $fatal(1);
    end

    // Presents one instruction and plays a memory that stalls n_stall request cycles,
    // then accepts, then answers n_wait cycles after acceptance (never if never_done).
    task automatic run_op(input logic i_rd, input logic i_wr, input logic i_halt,
                          input logic [15:0] i_alu, input logic [15:0] i_wd,
                          input logic [15:0] i_rdata, input int n_stall, input int n_wait,
                          input bit never_done,
                          output int o_stall, output int o_req, output int o_badreq,
                          output int o_dump, output int o_early,
                          output logic o_v, output logic o_err, output logic o_halt,
                          output logic [15:0] o_data);
        int  j;
        bit  busy;
        o_stall = 0; o_req = 0; o_badreq = 0; o_dump = 0; o_early = 0;
        @(negedge clk);
        in_valid = 1'b1; mem_read = i_rd; mem_write = i_wr; halt = i_halt;
        alu_result = i_alu; write_data = i_wd; m_data_out = i_rdata;
        m_stall = 1'b0; m_done = 1'b0;
        #1;
        if (stall_out) o_stall++;
        if (m_rd || m_wr) o_req++;
        if (m_createdump) o_dump++;
        busy = stall_out;
        j = 0;
        while (busy && j < 200) begin
            j++;
            @(negedge clk);
            if (j <= n_stall) begin
                m_stall = 1'b1; m_done = 1'b0;
            end else begin
                m_stall = 1'b0;
                m_done  = !never_done && (j == n_stall + 1 + n_wait);
            end
            #1;
            if (stall_out) o_stall++;
            if (m_rd || m_wr) begin
                o_req++;
                if (m_addr !== i_alu || m_data_in !== i_wd || m_rd !== !i_wr || m_wr !== i_wr)
                    o_badreq++;
            end
            if (m_createdump) o_dump++;
            if (wb_valid) o_early++;
            busy = stall_out;
        end
        @(posedge clk);
        #1;
        o_v = wb_valid; o_err = wb_err; o_halt = wb_halt; o_data = wb_data;
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; halt = 1'b0;
        m_stall = 1'b0; m_done = 1'b0;
    endtask

    int          s, r, b, d, e;
    logic        v, er, hl;
    logic [15:0] dt;

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; halt = 1'b1;
        alu_result = 16'h0040; write_data = 16'h1111;
        m_data_out = 16'h0; m_done = 1'b0; m_stall = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if ({stall_out, m_rd, m_wr, m_createdump} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: stall/rd/wr/dump=%b need 0000", {stall_out, m_rd, m_wr, m_createdump});
        end
        tests_run++;
        if ({wb_valid, wb_err, wb_halt} !== 3'b0 || wb_data !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_wb: v/err/halt=%b data=%h need 000 0000", {wb_valid, wb_err, wb_halt}, wb_data);
        end
        tests_run++;
        if (m_addr !== 16'h0 || m_data_in !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_bus: addr=%h din=%h need 0000 0000", m_addr, m_data_in);
        end
        in_valid = 1'b0; mem_read = 1'b0; halt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [15:0] a;
        run_op(0, 0, 0, 16'h1234, 16'h0, 16'h0, 0, 0, 0, s, r, b, d, e, v, er, hl, dt);
        tests_run++;
        if (v !== 1'b1 || dt !== 16'h1234 || er !== 1'b0 || s !== 0) begin
            tests_failed++;
            $display("FAIL pass_1234: v=%b data=%h err=%b stalls=%0d need 1 1234 0 0", v, dt, er, s);
        end
        for (int k = 0; k < 8; k++) begin
            a = 16'($urandom);
            run_op(0, 0, 0, a, 16'($urandom), 16'h0, 0, 0, 0, s, r, b, d, e, v, er, hl, dt);
            tests_run++;
            if (v !== 1'b1 || dt !== a || er !== 1'b0 || s !== 0 || r !== 0) begin
                tests_failed++;
                $display("FAIL pass_rand: v=%b data=%h err=%b stalls=%0d req=%0d need 1 %h 0 0 0", v, dt, er, s, r, a);
            end
        end
    endtask

    task automatic test_load_hit();
        run_op(1, 0, 0, 16'h0040, 16'h0, 16'hBEEF, 0, 0, 0, s, r, b, d, e, v, er, hl, dt);
        tests_run++;
        if (r !== 1 || b !== 0) begin
            tests_failed++;
            $display("FAIL load_hit_req: req_cycles=%0d bad=%0d need 1 0", r, b);
        end
        tests_run++;
        if (s !== 1) begin
            tests_failed++;
            $display("FAIL load_hit_stall: stall_cycles=%0d need 1", s);
        end
        tests_run++;
        if (v !== 1'b1 || dt !== 16'hBEEF || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_hit_wb: v=%b data=%h err=%b need 1 beef 0", v, dt, er);
        end
    endtask

    task automatic test_store_wait();
        run_op(0, 1, 0, 16'h0010, 16'h00AA, 16'h5555, 2, 3, 0, s, r, b, d, e, v, er, hl, dt);
        tests_run++;
        if (r !== 3 || b !== 0) begin
            tests_failed++;
            $display("FAIL store_wr_cycles: req=%0d bad=%0d need 3 0", r, b);
        end
        tests_run++;
        if (v !== 1'b1 || e !== 0 || er !== 1'b0 || dt !== 16'h0010 || s !== 6) begin
            tests_failed++;
            $display("FAIL store_wb: v=%b early=%0d err=%b data=%h stalls=%0d need 1 0 0 0010 6", v, e, er, dt, s);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (wb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL store_once: wb_valid=%b need 0", wb_valid);
        end
    endtask

    task automatic test_misaligned();
        run_op(1, 0, 0, 16'h0003, 16'h0, 16'h0, 0, 0, 0, s, r, b, d, e, v, er, hl, dt);
        tests_run++;
        if (r !== 0 || s !== 0 || v !== 1'b1 || er !== 1'b1 || dt !== 16'h0) begin
            tests_failed++;
            $display("FAIL misaligned: req=%0d stalls=%0d v=%b err=%b data=%h need 0 0 1 1 0000", r, s, v, er, dt);
        end
        run_op(1, 1, 0, 16'h0020, 16'h0, 16'h0, 0, 0, 0, s, r, b, d, e, v, er, hl, dt);
        tests_run++;
        if (r !== 0 || s !== 0 || v !== 1'b1 || er !== 1'b1 || dt !== 16'h0) begin
            tests_failed++;
            $display("FAIL rd_wr_conflict: req=%0d stalls=%0d v=%b err=%b data=%h need 0 0 1 1 0000", r, s, v, er, dt);
        end
    endtask

    task automatic test_timeout();
        run_op(1, 0, 0, 16'h0080, 16'h0, 16'h7777, 0, 0, 1, s, r, b, d, e, v, er, hl, dt);
        tests_run++;
        if (s !== TMO || v !== 1'b1 || er !== 1'b1 || dt !== 16'h0 || e !== 0) begin
            tests_failed++;
            $display("FAIL timeout: stalls=%0d v=%b err=%b data=%h early=%0d need %0d 1 1 0000 0", s, v, er, dt, e, TMO);
        end
        run_op(0, 0, 0, 16'hCAFE, 16'h0, 16'h0, 0, 0, 0, s, r, b, d, e, v, er, hl, dt);
        tests_run++;
        if (v !== 1'b1 || dt !== 16'hCAFE || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_timeout: v=%b data=%h err=%b need 1 cafe 0", v, dt, er);
        end
        run_op(1, 0, 0, 16'h0082, 16'h0, 16'h4321, 0, TMO - 1, 0, s, r, b, d, e, v, er, hl, dt);
        tests_run++;
        if (s !== TMO || er !== 1'b0 || dt !== 16'h4321) begin
            tests_failed++;
            $display("FAIL done_at_limit: stalls=%0d err=%b data=%h need %0d 0 4321", s, er, dt, TMO);
        end
        run_op(0, 1, 0, 16'h0084, 16'h9, 16'h0, 1, TMO - 1, 0, s, r, b, d, e, v, er, hl, dt);
        tests_run++;
        if (s !== TMO || er !== 1'b1 || dt !== 16'h0 || r !== 2) begin
            tests_failed++;
            $display("FAIL done_past_limit: stalls=%0d err=%b data=%h req=%0d need %0d 1 0000 2", s, er, dt, r, TMO);
        end
    endtask

    // Model: an access spends min(stalls+1+waits, TIMEOUT) cycles in flight; upstream
    // sees a stall for every cycle but the last; past the limit it is an error.
    task automatic test_random();
        int          kind, ns, nw, c, exp_s, exp_r;
        logic        rd_f, wr_f, exp_err;
        logic [15:0] a, wdat, rdat, exp_d;
        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 4));
            ns = int'($urandom_range(0, 3));
            nw = int'($urandom_range(0, 4));
            a = 16'($urandom); wdat = 16'($urandom); rdat = 16'($urandom);
            rd_f = 1'b0; wr_f = 1'b0;
            case (kind)
                1: begin rd_f = 1'b1; a[0] = 1'b0; end
                2: begin wr_f = 1'b1; a[0] = 1'b0; end
                3: begin rd_f = $urandom_range(0, 1) == 1; wr_f = !rd_f; a[0] = 1'b1; end
                4: begin rd_f = 1'b1; wr_f = 1'b1; end
                default: ;
            endcase
            if (kind == 0) begin
                exp_s = 0; exp_r = 0; exp_err = 1'b0; exp_d = a;
            end else if (kind >= 3) begin
                exp_s = 0; exp_r = 0; exp_err = 1'b1; exp_d = 16'h0;
            end else begin
                c = (ns + 1 + nw > TMO) ? TMO : ns + 1 + nw;
                exp_s = c;
                exp_r = (ns + 1 < c) ? ns + 1 : c;
                exp_err = (ns + 1 + nw > TMO);
                exp_d = exp_err ? 16'h0 : (wr_f ? a : rdat);
            end
            run_op(rd_f, wr_f, 0, a, wdat, rdat, ns, nw, 0, s, r, b, d, e, v, er, hl, dt);
            tests_run++;
            if (v !== 1'b1 || hl !== 1'b0 || er !== exp_err || dt !== exp_d) begin
                tests_failed++;
                $display("FAIL rand_wb[%0d]: v=%b halt=%b err=%b data=%h need 1 0 %b %h", k, v, hl, er, dt, exp_err, exp_d);
            end
            tests_run++;
            if (s !== exp_s || r !== exp_r || b !== 0 || e !== 0 || d !== 0) begin
                tests_failed++;
                $display("FAIL rand_bus[%0d]: stalls=%0d req=%0d bad=%0d early=%0d dump=%0d need %0d %0d 0 0 0", k, s, r, b, e, d, exp_s, exp_r);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        in_valid = 1'b1; mem_read = 1'b1; alu_result = 16'h0100; write_data = 16'h0;
        @(negedge clk);
        m_stall = 1'b0; m_done = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (stall_out !== 1'b1 || m_rd !== 1'b0 || m_addr !== 16'h0100) begin
            tests_failed++;
            $display("FAIL wait_state: stall=%b rd=%b addr=%h need 1 0 0100", stall_out, m_rd, m_addr);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({stall_out, m_rd, m_wr, wb_valid} !== 4'b0 || m_addr !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_in_wait: stall/rd/wr/v=%b addr=%h need 0000 0000", {stall_out, m_rd, m_wr, wb_valid}, m_addr);
        end
        in_valid = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (m_rd !== 1'b0 || stall_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_retry: rd=%b stall=%b need 0 0", m_rd, stall_out);
        end
    endtask

    task automatic test_halt();
        run_op(0, 0, 1, 16'h0ABC, 16'h0, 16'h0, 0, 0, 0, s, r, b, d, e, v, er, hl, dt);
        tests_run++;
        if (d !== 1 || s !== 0 || v !== 1'b1 || hl !== 1'b1 || dt !== 16'h0ABC || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt: dump=%0d stalls=%0d v=%b halt=%b data=%h err=%b need 1 0 1 1 0abc 0", d, s, v, hl, dt, er);
        end
        run_op(1, 0, 0, 16'h0040, 16'h0, 16'h0, 0, 0, 0, s, r, b, d, e, v, er, hl, dt);
        tests_run++;
        if (r !== 0 || s !== 0 || d !== 0 || v !== 1'b0) begin
            tests_failed++;
            $display("FAIL halted_ignores: req=%0d stalls=%0d dump=%0d v=%b need 0 0 0 0", r, s, d, v);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_hit();
        test_store_wait();
        test_misaligned();
        test_timeout();
        test_random();
        test_reset_in_wait();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
